// File: rtl/unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Purpose:
//   Shares one single-ported unified memory between instruction fetch and the
//   MEM-stage data port. The memory has a 1-cycle read latency. The arbiter
//   grants at most one access per cycle. Data accesses normally win because
//   they belong to older instructions. A starvation counter makes fetch win
//   after STARVE_LIMIT consecutive denied cycles. Each read response is routed
//   back to the port that issued it.
//
// Parameters:
//   STARVE_LIMIT  consecutive denied fetch cycles before fetch wins (1..15)
//
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   if_req, if_addr       fetch request (read only)
//   if_gnt                fetch accepted this cycle
//   if_rvalid, if_rdata   fetch response (one cycle after if_gnt)
//   stall_if              fetch requested but not granted
//   d_req, d_we, d_addr,
//   d_wdata, d_wstrb      data request (d_we=1 store, 0 load)
//   d_gnt                 data accepted this cycle
//   d_rvalid, d_rdata     load response (one cycle after a load grant)
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
//                         memory command (all zero when idle; wstrb 0 on reads)
//   mem_rdata             memory read data, valid the cycle after a read
//
// Optional feature (macro ARB_PERF_EN):
//   perf_conflicts        cycles with both ports requesting (wraps at 2^32)
//   perf_forced           contested cycles won by fetch via starvation rule
// ----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        stall_if,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0] perf_conflicts,
    output logic [31:0] perf_forced
`endif
);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_sel_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    resp_sel_t  resp_sel;
    resp_sel_t  resp_sel_next;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;
    logic       contested;
    logic       force_if;
    logic       if_win;
    logic       d_win;

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_sel   <= RESP_NONE;
            starve_cnt <= 4'd0;
        end else begin
            resp_sel   <= resp_sel_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Every output is held at zero while reset is asserted. This includes any
    // response left over from a grant in the previous cycle.
    always_comb begin
        contested       = 1'b0;
        force_if        = 1'b0;
        if_win          = 1'b0;
        d_win           = 1'b0;
        if_gnt          = 1'b0;
        d_gnt           = 1'b0;
        stall_if        = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = 32'd0;
        mem_wdata       = 32'd0;
        mem_wstrb       = 4'd0;
        if_rvalid       = 1'b0;
        if_rdata        = 32'd0;
        d_rvalid        = 1'b0;
        d_rdata         = 32'd0;
        resp_sel_next   = RESP_NONE;
        starve_cnt_next = 4'd0;

        contested = if_req && d_req;
        force_if  = (starve_cnt == LIMIT);
        if_win    = !reset && if_req && (!d_req || force_if);
        d_win     = !reset && d_req && !if_win;

        if_gnt   = if_win;
        d_gnt    = d_win;
        stall_if = !reset && if_req && !if_win;

        if (if_win) begin
            mem_req  = 1'b1;
            mem_addr = if_addr;
        end else if (d_win) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            // Byte enables only mean something for stores.
            mem_wstrb = d_we ? d_wstrb : 4'd0;
        end

        if (!reset) begin
            if_rvalid = (resp_sel == RESP_IF);
            d_rvalid  = (resp_sel == RESP_D);
        end
        if (if_rvalid) begin
            if_rdata = mem_rdata;
        end
        if (d_rvalid) begin
            d_rdata = mem_rdata;
        end

        if (if_win) begin
            resp_sel_next = RESP_IF;
        end else if (d_win && !d_we) begin
            resp_sel_next = RESP_D;
        end

        // The counter only counts cycles in which fetch was actually asking.
        // Dropping if_req, or winning, restarts the count.
        if (if_req && !if_win) begin
            starve_cnt_next = (starve_cnt < LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
        end
    end

`ifdef ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_conflicts <= 32'd0;
            perf_forced    <= 32'd0;
        end else begin
            if (contested) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
            if (contested && force_if) begin
                perf_forced <= perf_forced + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Directed vector bench for unified_mem_arbiter. A table of single-cycle
// records holds the inputs and hand-computed outputs. Hand-written sequences
// cover contention with the starvation limit, counter clearing, and reset
// during a read. A second instance with STARVE_LIMIT=1 shares the inputs and
// is checked for strict alternation under contention.
// ----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        stall_if;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    logic        l1_if_gnt;
    logic        l1_if_rvalid;
    logic [31:0] l1_if_rdata;
    logic        l1_stall_if;
    logic        l1_d_gnt;
    logic        l1_d_rvalid;
    logic [31:0] l1_d_rdata;
    logic        l1_mem_req;
    logic        l1_mem_we;
    logic [31:0] l1_mem_addr;
    logic [31:0] l1_mem_wdata;
    logic [3:0]  l1_mem_wstrb;

`ifdef ARB_PERF_EN
    logic [31:0] perf_conflicts;
    logic [31:0] perf_forced;
    logic [31:0] l1_perf_conflicts;
    logic [31:0] l1_perf_forced;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    unified_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .stall_if(stall_if),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
        , .perf_conflicts(perf_conflicts), .perf_forced(perf_forced)
`endif
    );

    unified_mem_arbiter #(.STARVE_LIMIT(1)) dut_lim1 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(l1_if_gnt),
        .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata), .stall_if(l1_stall_if),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
        .mem_req(l1_mem_req), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_wstrb(l1_mem_wstrb), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
        , .perf_conflicts(l1_perf_conflicts), .perf_forced(l1_perf_forced)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_wstrb;
        logic [31:0] mem_rdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_stall_if;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic [3:0]  e_mem_wstrb;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_d_rvalid;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic applyStimulus(input vec_t v);
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        d_req     = v.d_req;
        d_we      = v.d_we;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        d_wstrb   = v.d_wstrb;
        mem_rdata = v.mem_rdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkVector(input vec_t v, input string tag);
        checkOutput({tag, " if_gnt"},    32'(if_gnt),    32'(v.e_if_gnt));
        checkOutput({tag, " d_gnt"},     32'(d_gnt),     32'(v.e_d_gnt));
        checkOutput({tag, " stall_if"},  32'(stall_if),  32'(v.e_stall_if));
        checkOutput({tag, " mem_req"},   32'(mem_req),   32'(v.e_mem_req));
        checkOutput({tag, " mem_we"},    32'(mem_we),    32'(v.e_mem_we));
        checkOutput({tag, " mem_addr"},  mem_addr,       v.e_mem_addr);
        checkOutput({tag, " mem_wdata"}, mem_wdata,      v.e_mem_wdata);
        checkOutput({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.e_mem_wstrb));
        checkOutput({tag, " if_rvalid"}, 32'(if_rvalid), 32'(v.e_if_rvalid));
        checkOutput({tag, " if_rdata"},  if_rdata,       v.e_if_rdata);
        checkOutput({tag, " d_rvalid"},  32'(d_rvalid),  32'(v.e_d_rvalid));
        checkOutput({tag, " d_rdata"},   d_rdata,        v.e_d_rdata);
    endtask

    task automatic driveIdle();
        if_req    = 1'b0;
        if_addr   = 32'd0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'd0;
        d_wdata   = 32'd0;
        d_wstrb   = 4'd0;
        mem_rdata = 32'd0;
    endtask

    task automatic driveContested(input logic [31:0] rdata);
        if_req    = 1'b1;
        if_addr   = 32'h0000_0040;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h0000_0080;
        d_wdata   = 32'd0;
        d_wstrb   = 4'd0;
        mem_rdata = rdata;
    endtask

    task automatic doReset();
        reset = 1'b1;
        driveIdle();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0,
                    1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h13579BDF,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF,
                    1'b1, 32'h13579BDF, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hAAAA5555,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                    1'b0, 32'h0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h11223344, 4'h0, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h11223344, 4'h0,
                    1'b0, 32'h0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h22222222,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0,
                    1'b0, 32'h0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0,
                    1'b0, 32'h0, 1'b1, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h304, 32'h0, 4'h0, 32'h01020304,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h304, 32'h0, 4'h0,
                    1'b1, 32'h01020304, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BADF00D,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                    1'b0, 32'h0, 1'b1, 32'h0BADF00D};
        vecs[8] = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h600, 32'h77, 4'h3, 32'h33,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h600, 32'h77, 4'h3,
                    1'b0, 32'h0, 1'b0, 32'h0};
        vecs[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h99,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                    1'b0, 32'h0, 1'b0, 32'h0};

        // Reset state.
        reset = 1'b1;
        driveIdle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset if_gnt",    32'(if_gnt),    32'd0);
        checkOutput("reset d_gnt",     32'(d_gnt),     32'd0);
        checkOutput("reset mem_req",   32'(mem_req),   32'd0);
        checkOutput("reset if_rvalid", 32'(if_rvalid), 32'd0);
        checkOutput("reset d_rvalid",  32'(d_rvalid),  32'd0);
        checkOutput("reset stall_if",  32'(stall_if),  32'd0);
        nextCycle();
        reset = 1'b0;

        // Table-driven single-cycle vectors; each expectation includes the
        // response for the previous row's grant.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clock);
            checkVector(vecs[i], $sformatf("vec%0d", i));
            nextCycle();
        end

        // Contention for 6 cycles: data wins 0-3, fetch in 4, data in 5.
        // The STARVE_LIMIT=1 instance alternates data/fetch.
        doReset();
        for (int i = 0; i < 6; i++) begin
            driveContested(32'h1000 + 32'(i));
            @(negedge clock);
            checkOutput($sformatf("cont%0d if_gnt", i),   32'(if_gnt),   32'(i == 4));
            checkOutput($sformatf("cont%0d d_gnt", i),    32'(d_gnt),    32'(i != 4));
            checkOutput($sformatf("cont%0d stall_if", i), 32'(stall_if), 32'(i != 4));
            checkOutput($sformatf("cont%0d mem_addr", i), mem_addr, (i == 4) ? 32'h40 : 32'h80);
            checkOutput($sformatf("cont%0d if_rvalid", i), 32'(if_rvalid), 32'(i == 5));
            checkOutput($sformatf("cont%0d d_rvalid", i),  32'(d_rvalid),  32'(i != 0 && i != 5));
            checkOutput($sformatf("cont%0d if_rdata", i), if_rdata, (i == 5) ? 32'h1005 : 32'h0);
            checkOutput($sformatf("cont%0d d_rdata", i),  d_rdata,
                        (i != 0 && i != 5) ? 32'h1000 + 32'(i) : 32'h0);
            checkOutput($sformatf("lim1 cont%0d if_gnt", i), 32'(l1_if_gnt), 32'(i % 2 == 1));
            checkOutput($sformatf("lim1 cont%0d d_gnt", i),  32'(l1_d_gnt),  32'(i % 2 == 0));
            nextCycle();
        end
        driveIdle();
        mem_rdata = 32'h1006;
        @(negedge clock);
        checkOutput("cont tail d_rvalid",  32'(d_rvalid),  32'd1);
        checkOutput("cont tail d_rdata",   d_rdata,        32'h1006);
        checkOutput("cont tail if_rvalid", 32'(if_rvalid), 32'd0);
`ifdef ARB_PERF_EN
        checkOutput("perf_conflicts", perf_conflicts, 32'd6);
        checkOutput("perf_forced",    perf_forced,    32'd1);
`endif
        nextCycle();

        // Dropping if_req clears the count: 3 losses, a data-only cycle,
        // then 4 more data wins before fetch is forced.
        doReset();
        for (int i = 0; i < 3; i++) begin
            driveContested(32'h0);
            nextCycle();
        end
        driveIdle();
        d_req  = 1'b1;
        d_addr = 32'h0000_0700;
        @(negedge clock);
        checkOutput("drop d_gnt",    32'(d_gnt),    32'd1);
        checkOutput("drop stall_if", 32'(stall_if), 32'd0);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            driveContested(32'h0);
            @(negedge clock);
            checkOutput($sformatf("clear%0d if_gnt", i), 32'(if_gnt), 32'(i == 4));
            nextCycle();
        end

        // Reset while a load response is pending and a new load is requested.
        doReset();
        driveIdle();
        d_req  = 1'b1;
        d_addr = 32'h0000_0500;
        @(negedge clock);
        checkOutput("rstrd grant d_gnt", 32'(d_gnt), 32'd1);
        nextCycle();
        reset     = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(negedge clock);
        checkOutput("rstrd in-reset d_rvalid", 32'(d_rvalid), 32'd0);
        checkOutput("rstrd in-reset d_rdata",  d_rdata,       32'd0);
        checkOutput("rstrd in-reset mem_req",  32'(mem_req),  32'd0);
        nextCycle();
        reset = 1'b0;
        driveIdle();
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        checkOutput("rstrd after d_rvalid",  32'(d_rvalid),  32'd0);
        checkOutput("rstrd after d_rdata",   d_rdata,        32'd0);
        checkOutput("rstrd after if_rvalid", 32'(if_rvalid), 32'd0);
        checkOutput("rstrd after mem_req",   32'(mem_req),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported, 1-cycle-latency unified memory between the pipeline's instruction-fetch port and its MEM-stage data port. Grants at most one access per cycle, routes the registered read response back to the port that issued it, and drives a fetch stall when fetch loses arbitration. Data accesses have priority because they belong to older instructions. A starvation counter forces a fetch grant after a bounded number of consecutive losses.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive denied fetch cycles after which fetch wins the next contested cycle. Legal range 1..15.
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `if_req` input 1: fetch request (read only).
- `if_addr` input 32: fetch byte address.
- `if_gnt` output 1: fetch accepted this cycle.
- `if_rvalid` output 1: `if_rdata` valid (one cycle after `if_gnt`).
- `if_rdata` output 32: fetched instruction.
- `stall_if` output 1: `if_req && !if_gnt`; holds the PC and IF/ID.
- `d_req` input 1: data request.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input 32: data byte address.
- `d_wdata` input 32: store data.
- `d_wstrb` input 4: store byte enables.
- `d_gnt` output 1: data access accepted this cycle.
- `d_rvalid` output 1: load data valid (one cycle after a load `d_gnt`).
- `d_rdata` output 32: load data.
- `mem_req` output 1: memory access this cycle.
- `mem_we` output 1: memory write.
- `mem_addr` output 32: memory byte address.
- `mem_wdata` output 32: memory write data.
- `mem_wstrb` output 4: memory byte enables (0000 on reads).
- `mem_rdata` input 32: read data, valid the cycle after a `mem_req` with `mem_we=0`.

## Operation
- Grant logic is combinational from the requests and the registered state.
- **Only one port requesting:** that port wins.
- **Both ports requesting:**
  - Data wins, unless `starve_cnt == STARVE_LIMIT`.
  - In that case fetch wins and data sees `d_gnt=0` and must hold.
- **Starvation counter:** `starve_cnt` is 4 bits.
  - Increments when `if_req && !if_gnt`.
  - Clears to 0 when `if_gnt` is asserted or `if_req` is 0.
  - Saturates at `STARVE_LIMIT`.
- **Memory port:** the winner's `addr`/`we`/`wdata`/`wstrb` are muxed onto the `mem_*` signals. With no winner, `mem_req=0`, `mem_*` are 0 and `mem_wstrb=0000`.
- **Requester rule:** a requester holds `req` and its payload stable until it sees `gnt`. `gnt` is a single-cycle completion of acceptance.
- **Response routing register `resp_sel`:** states `NONE`, `IF`, `D`.
  - Next-state is `IF` on a fetch grant, `D` on a load grant, and `NONE` on a store grant or idle.
  - `if_rvalid = (resp_sel==IF)`, `d_rvalid = (resp_sel==D)`.
  - `if_rdata`/`d_rdata` carry `mem_rdata` when their rvalid is set and are 0 otherwise.
- Stores never generate an rvalid.
- Back-to-back grants to the same or alternating ports are allowed every cycle. A response and a new grant coexist in the same cycle.

## Timing
- Grant latency: 0 cycles (same cycle as `req`).
- Read latency: 1 cycle from `gnt` to `rvalid`.
- **Reset:**
  - Every output is 0.
  - `resp_sel=NONE`, `starve_cnt=0`.
  - A read granted in the cycle reset is asserted produces no rvalid afterward.
- Throughput: 1 access/cycle total.
- **Boundary cases:**
  - `STARVE_LIMIT=1`: fetch and data alternate under continuous contention.
  - A fetch loss in the same cycle that `if_req` drops does not increment the counter.
  - `d_req` with `d_we=1` and `d_wstrb=0000` is still granted and still drives `mem_req`.

## Configuration
- `ARB_PERF_EN`
  - When defined, adds outputs `perf_conflicts` (output, 32) and `perf_forced` (output, 32), both reset to 0 and wrapping modulo 2^32.
  - `perf_conflicts` counts cycles with `if_req && d_req`.
  - `perf_forced` counts cycles in which fetch won a contested cycle via the starvation rule.
  - When undefined, neither port nor counter exists, and arbitration behaviour is identical.

## Test plan
- **Fetch only:** `if_req=1`, `if_addr=0x10` -> `if_gnt=1`, `mem_addr=0x10`, `mem_we=0`; next cycle `if_rvalid=1` with `if_rdata=mem_rdata`.
- **Store only:** `d_req=1`, `d_we=1`, `d_addr=0x100`, `d_wdata=0xDEADBEEF`, `d_wstrb=1111` -> `mem_we=1` with matching data; no rvalid next cycle.
- **Contention, default limit:** `if_req` and `d_req` (load) held high for 6 cycles -> `d_gnt` in cycles 0-3, `if_gnt` in cycle 4, `d_gnt` in cycle 5; `stall_if=1` in cycles 0-3 and 5; responses routed to the matching port each following cycle.
- **Interleaved routing:** fetch grant then load grant on consecutive cycles -> `if_rvalid` then `d_rvalid` on consecutive cycles, never both set.
- **Reset mid-read:** load granted and `reset=1` in the same cycle -> next cycle all outputs 0 and `d_rvalid=0`.
- **With `ARB_PERF_EN`:** the contention scenario above -> `perf_conflicts=6`, `perf_forced=1`.
